// File: rtl/lfsr_crc_pkg.sv
// lfsr_crc_pkg: shared constants for the parallel LFSR/CRC blocks.
//   - LFSR topology names accepted by LFSR_CONFIG
//   - implementation style names accepted by STYLE
//   - standard CRC-32 (IEEE 802.3) polynomial and initial value
package lfsr_crc_pkg;

  localparam string CFG_GALOIS      = "GALOIS";
  localparam string CFG_FIBONACCI   = "FIBONACCI";

  localparam string STYLE_LOOP      = "LOOP";
  localparam string STYLE_REDUCTION = "REDUCTION";
  localparam string STYLE_AUTO      = "AUTO";

  localparam int          CRC32_WIDTH = 32;
  localparam logic [31:0] CRC32_POLY  = 32'h04c11db7;
  localparam logic [31:0] CRC32_INIT  = 32'hffffffff;

endpackage

// File: rtl/lfsr.sv
// lfsr: purely combinational parallel LFSR step. Advances the state by
// DATA_WIDTH serial steps in one evaluation.
// Ports:
//   data_in   [DATA_WIDTH-1:0]  data bits to feed
//   state_in  [LFSR_WIDTH-1:0]  current LFSR state
//   data_out  [DATA_WIDTH-1:0]  per-step feedback bit (scrambler output)
//   state_out [LFSR_WIDTH-1:0]  state after DATA_WIDTH steps
module lfsr
  import lfsr_crc_pkg::*;
#(
  parameter int                    LFSR_WIDTH        = 31,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY         = 31'h10000001,
  parameter string                 LFSR_CONFIG       = CFG_FIBONACCI,
  parameter bit                    LFSR_FEED_FORWARD = 1'b0,
  parameter bit                    REVERSE           = 1'b0,
  parameter int                    DATA_WIDTH        = 8,
  parameter string                 STYLE             = STYLE_AUTO
) (
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [LFSR_WIDTH-1:0] state_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [LFSR_WIDTH-1:0] state_out
);

  localparam int W = LFSR_WIDTH;
  localparam int D = DATA_WIDTH;
  localparam int N = LFSR_WIDTH + DATA_WIDTH;

  localparam bit IS_GALOIS     = (LFSR_CONFIG == CFG_GALOIS);
  localparam bit USE_LOOP      = (STYLE == STYLE_LOOP);
  localparam bit USE_REDUCTION = (STYLE == STYLE_REDUCTION) || (STYLE == STYLE_AUTO);

  // Symbolic simulation of the serial LFSR: every bit is tracked as an XOR
  // mask over the input vector {data_in, state_in}. Returns the mask for
  // output o (o < W selects state_out[o], otherwise data_out[o-W]).
  function automatic logic [N-1:0] calc_mask(input int o);
    logic [W-1:0][N-1:0] st;
    logic [D-1:0][N-1:0] dout;
    logic [N-1:0]        dm;
    logic [N-1:0]        fb;
    logic [N-1:0]        fbs;
    logic [N-1:0]        res;
    int                  idx;
    dout = '0;
    // In reflected mode the internal state is the bit-reversed input state.
    for (int i = 0; i < W; i++) begin
      st[i] = '0;
      st[i][REVERSE ? (W - 1 - i) : i] = 1'b1;
    end
    for (int k = 0; k < D; k++) begin
      idx = REVERSE ? k : (D - 1 - k);
      dm = '0;
      dm[W + idx] = 1'b1;
      if (IS_GALOIS) begin
        fb  = st[W-1] ^ dm;
        fbs = LFSR_FEED_FORWARD ? dm : fb;
        for (int i = W - 1; i > 0; i--) begin
          st[i] = st[i-1] ^ (LFSR_POLY[i] ? fbs : '0);
        end
        st[0] = LFSR_POLY[0] ? fbs : '0;
      end else begin
        fb = dm;
        for (int i = 0; i < W; i++) begin
          if (LFSR_POLY[i]) fb = fb ^ st[i];
        end
        for (int i = W - 1; i > 0; i--) begin
          st[i] = st[i-1];
        end
        st[0] = LFSR_FEED_FORWARD ? dm : fb;
      end
      dout[idx] = fb;
    end
    if (o < W) res = st[REVERSE ? (W - 1 - o) : o];
    else       res = dout[o - W];
    return res;
  endfunction

  genvar gi;

  generate
    if (USE_LOOP && !USE_REDUCTION) begin : g_loop
      logic [W-1:0] loop_s;
      logic [D-1:0] loop_dout;
      logic         loop_fb;
      logic         loop_fbs;
      logic         loop_d;

      always_comb begin
        loop_s    = '0;
        loop_dout = '0;
        loop_fb   = 1'b0;
        loop_fbs  = 1'b0;
        loop_d    = 1'b0;
        for (int i = 0; i < W; i++) begin
          loop_s[i] = REVERSE ? state_in[W-1-i] : state_in[i];
        end
        for (int k = 0; k < D; k++) begin
          loop_d = REVERSE ? data_in[k] : data_in[D-1-k];
          if (IS_GALOIS) begin
            loop_fb  = loop_s[W-1] ^ loop_d;
            loop_fbs = LFSR_FEED_FORWARD ? loop_d : loop_fb;
            loop_s   = (loop_s << 1) ^ (loop_fbs ? LFSR_POLY : '0);
          end else begin
            loop_fb  = (^(loop_s & LFSR_POLY)) ^ loop_d;
            loop_fbs = LFSR_FEED_FORWARD ? loop_d : loop_fb;
            loop_s   = {loop_s[W-2:0], loop_fbs};
          end
          if (REVERSE) loop_dout[k] = loop_fb;
          else         loop_dout[D-1-k] = loop_fb;
        end
        for (int i = 0; i < W; i++) begin
          state_out[i] = REVERSE ? loop_s[W-1-i] : loop_s[i];
        end
        data_out = loop_dout;
      end
    end else begin : g_reduction
      logic [N-1:0] in_vec;
      assign in_vec = {data_in, state_in};

      for (gi = 0; gi < W; gi++) begin : g_state
        localparam logic [N-1:0] MASK = calc_mask(gi);
        assign state_out[gi] = ^(in_vec & MASK);
      end

      for (gi = 0; gi < D; gi++) begin : g_data
        localparam logic [N-1:0] MASK = calc_mask(W + gi);
        assign data_out[gi] = ^(in_vec & MASK);
      end
    end
  endgenerate

endmodule

// File: rtl/lfsr_crc.sv
// lfsr_crc: parallel CRC generator. Consumes DATA_WIDTH bits per valid
// beat, keeps the running CRC in state_reg and presents the (optionally
// inverted) result on a registered output.
// Ports:
//   clk           clock, rising edge
//   rst           synchronous active-high reset (clears between frames)
//   data_in       [DATA_WIDTH-1:0] data word
//   data_in_valid advance the CRC by data_in this cycle
//   crc_out       [LFSR_WIDTH-1:0] registered CRC result (0 after reset)
module lfsr_crc
  import lfsr_crc_pkg::*;
#(
  parameter int                    LFSR_WIDTH  = 31,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY   = 31'h10000001,
  parameter logic [LFSR_WIDTH-1:0] LFSR_INIT   = '1,
  parameter string                 LFSR_CONFIG = CFG_FIBONACCI,
  parameter bit                    REVERSE     = 1'b0,
  parameter bit                    INVERT      = 1'b1,
  parameter int                    DATA_WIDTH  = 8,
  parameter string                 STYLE       = STYLE_AUTO
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_valid,
  output logic [LFSR_WIDTH-1:0] crc_out
);

  logic [LFSR_WIDTH-1:0] state_reg;
  logic [LFSR_WIDTH-1:0] output_reg;
  logic [LFSR_WIDTH-1:0] state_next;
  logic [DATA_WIDTH-1:0] lfsr_data_unused;

  lfsr #(
    .LFSR_WIDTH        (LFSR_WIDTH),
    .LFSR_POLY         (LFSR_POLY),
    .LFSR_CONFIG       (LFSR_CONFIG),
    .LFSR_FEED_FORWARD (1'b0),
    .REVERSE           (REVERSE),
    .DATA_WIDTH        (DATA_WIDTH),
    .STYLE             (STYLE)
  ) u_lfsr (
    .data_in   (data_in),
    .state_in  (state_reg),
    .data_out  (lfsr_data_unused),
    .state_out (state_next)
  );

  // Reset wins over a same-cycle valid beat; that beat is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= LFSR_INIT;
      output_reg <= '0;
    end else if (data_in_valid) begin
      state_reg  <= state_next;
      output_reg <= INVERT ? ~state_next : state_next;
    end
  end

  assign crc_out = output_reg;

endmodule

// File: tb/tb_lfsr_crc.sv
module tb_lfsr_crc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] data = '0;
  logic        valid = 1'b0;
  logic [31:0] crc_loop;
  logic [31:0] crc_red;

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [31:0] model_crc = 32'hffffffff;

  localparam logic [63:0] ASCII_12345678 = 64'h3837363534333231;

  always #5 clk = ~clk;

  lfsr_crc #(
    .LFSR_WIDTH(32), .LFSR_POLY(32'h04c11db7), .LFSR_INIT(32'hffffffff),
    .LFSR_CONFIG("GALOIS"), .REVERSE(1'b1), .INVERT(1'b1),
    .DATA_WIDTH(64), .STYLE("LOOP")
  ) dut_loop (
    .clk(clk), .rst(rst), .data_in(data), .data_in_valid(valid), .crc_out(crc_loop)
  );

  lfsr_crc #(
    .LFSR_WIDTH(32), .LFSR_POLY(32'h04c11db7), .LFSR_INIT(32'hffffffff),
    .LFSR_CONFIG("GALOIS"), .REVERSE(1'b1), .INVERT(1'b1),
    .DATA_WIDTH(64), .STYLE("REDUCTION")
  ) dut_red (
    .clk(clk), .rst(rst), .data_in(data), .data_in_valid(valid), .crc_out(crc_red)
  );

  // Byte-wise reflected CRC-32 (table-free software form), bytes taken
  // from the low end of the word first.
  function automatic logic [31:0] crc32_update(input logic [31:0] c, input logic [63:0] w);
    logic [31:0] r;
    r = c;
    for (int b = 0; b < 8; b++) begin
      r = r ^ {24'h0, w[8*b +: 8]};
      for (int k = 0; k < 8; k++) begin
        r = r[0] ? ((r >> 1) ^ 32'hedb88320) : (r >> 1);
      end
    end
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_crc = 32'hffffffff;
  endtask

  // Drive one valid beat at the falling edge; return #1 after the
  // capturing rising edge so the caller can sample the result.
  task automatic send_beat(input logic [63:0] w);
    @(negedge clk);
    data  = w;
    valid = 1'b1;
    model_crc = crc32_update(model_crc, w);
    @(posedge clk);
    #1;
  endtask

  task automatic send_idle();
    @(negedge clk);
    valid = 1'b0;
    data  = {$urandom, $urandom};
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (crc_loop !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_loop crc_out=%h expected=%h", crc_loop, 32'h0);
    end
    tests_run++;
    if (crc_red !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_reduction crc_out=%h expected=%h", crc_red, 32'h0);
    end
    // Mid-stream reset discards the accumulated CRC.
    send_beat({$urandom, $urandom});
    send_beat({$urandom, $urandom});
    do_reset();
    send_beat(ASCII_12345678);
    tests_run++;
    if (crc_loop !== 32'h9ae0daaf || crc_red !== 32'h9ae0daaf) begin
      tests_failed++;
      $display("FAIL midstream_reset loop=%h reduction=%h expected=%h", crc_loop, crc_red, 32'h9ae0daaf);
    end
    $display("[TB] reset: crc_out loop=%h reduction=%h", crc_loop, crc_red);
  endtask

  task automatic test_single_beat();
    do_reset();
    send_beat(ASCII_12345678);
    tests_run++;
    if (crc_loop !== 32'h9ae0daaf) begin
      tests_failed++;
      $display("FAIL single_beat_loop crc_out=%h expected=%h", crc_loop, 32'h9ae0daaf);
    end
    tests_run++;
    if (crc_red !== 32'h9ae0daaf) begin
      tests_failed++;
      $display("FAIL single_beat_reduction crc_out=%h expected=%h", crc_red, 32'h9ae0daaf);
    end
    $display("[TB] single beat 12345678: loop=%h reduction=%h", crc_loop, crc_red);
  endtask

  task automatic test_zero_beat();
    do_reset();
    send_beat(64'h0);
    tests_run++;
    if (crc_loop !== 32'h6522df69 || crc_red !== 32'h6522df69) begin
      tests_failed++;
      $display("FAIL zero_beat loop=%h reduction=%h expected=%h", crc_loop, crc_red, 32'h6522df69);
    end
    $display("[TB] zero beat: loop=%h reduction=%h", crc_loop, crc_red);
  endtask

  task automatic test_valid_gap();
    do_reset();
    send_beat(ASCII_12345678);
    for (int i = 0; i < 5; i++) begin
      send_idle();
      tests_run++;
      if (crc_loop !== 32'h9ae0daaf || crc_red !== 32'h9ae0daaf) begin
        tests_failed++;
        $display("FAIL valid_gap[%0d] loop=%h reduction=%h expected=%h", i, crc_loop, crc_red, 32'h9ae0daaf);
      end
      $display("[TB] idle %0d: loop=%h reduction=%h", i, crc_loop, crc_red);
    end
  endtask

  task automatic test_reset_priority();
    do_reset();
    send_beat({$urandom, $urandom});
    @(negedge clk);
    rst   = 1'b1;
    valid = 1'b1;
    data  = ASCII_12345678;
    @(posedge clk);
    #1;
    tests_run++;
    if (crc_loop !== 32'h0 || crc_red !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_priority loop=%h reduction=%h expected=%h", crc_loop, crc_red, 32'h0);
    end
    @(negedge clk);
    rst   = 1'b0;
    valid = 1'b0;
    model_crc = 32'hffffffff;
    send_beat(ASCII_12345678);
    tests_run++;
    if (crc_loop !== 32'h9ae0daaf || crc_red !== 32'h9ae0daaf) begin
      tests_failed++;
      $display("FAIL reset_priority_after loop=%h reduction=%h expected=%h", crc_loop, crc_red, 32'h9ae0daaf);
    end
    $display("[TB] reset priority: loop=%h reduction=%h", crc_loop, crc_red);
  endtask

  task automatic test_chaining();
    logic [63:0] w;
    int          len;
    for (int f = 0; f < 12; f++) begin
      do_reset();
      len = $urandom_range(1, 8);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 2) == 0) send_idle();
        w = {$urandom, $urandom};
        send_beat(w);
        tests_run++;
        if (crc_loop !== ~model_crc) begin
          tests_failed++;
          $display("FAIL chain_loop f%0d b%0d crc_out=%h expected=%h", f, b, crc_loop, ~model_crc);
        end
        tests_run++;
        if (crc_red !== crc_loop) begin
          tests_failed++;
          $display("FAIL chain_styles_agree f%0d b%0d reduction=%h loop=%h", f, b, crc_red, crc_loop);
        end
        $display("[TB] frame %0d beat %0d data=%h crc loop=%h reduction=%h", f, b, w, crc_loop, crc_red);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] w;
    do_reset();
    for (int b = 0; b < 16; b++) begin
      w = {$urandom, $urandom};
      send_beat(w);
      tests_run++;
      if (crc_loop !== ~model_crc || crc_red !== ~model_crc) begin
        tests_failed++;
        $display("FAIL back_to_back b%0d loop=%h reduction=%h expected=%h", b, crc_loop, crc_red, ~model_crc);
      end
      $display("[TB] b2b beat %0d data=%h crc loop=%h reduction=%h", b, w, crc_loop, crc_red);
    end
    @(negedge clk);
    valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_zero_beat();
    test_valid_gap();
    test_reset_priority();
    test_chaining();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
